ritc_align_sequencer: RTL and testbench

Autonomous training sequencer for the RITC six-channel input datapath. On `start_i` it enables and resets the datapath, then handles each channel in turn. For each channel it sweeps the IDELAY taps, finds the widest contiguous window where the deserialised data matches the training pattern, and loads the tap at the centre of that window. If no usable window is found, it issues a bitslip and sweeps again. It is a bus master on the datapath user register bus and replaces manual alignment from software.

---
 rtl/ritc_align_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ritc_align_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ritc_align_sequencer.sv
// RITC input datapath alignment sequencer: sweeps IDELAY taps per channel, finds the
// widest matching window, loads its centre tap and retries with bitslips on failure.
module ritc_align_sequencer #(
    parameter int NUM_CH   = 6,
    parameter int NTAPS    = 32,
    parameter int SETTLE   = 16,
    parameter int CHECK    = 64,
    parameter int MIN_WIN  = 4,
    parameter int MAX_SLIP = 4
) (
    input  logic              user_clk_i,
    input  logic              user_rst_n_i,
    input  logic              start_i,
    input  logic [NUM_CH-1:0] match_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [NUM_CH-1:0] fail_ch_o,
    output logic              bus_sel_o,
    output logic              bus_wr_o,
    output logic [3:0]        bus_addr_o,
    output logic [31:0]       bus_dat_o
);

    localparam int CNT_W = $clog2(((SETTLE > CHECK) ? SETTLE : CHECK) + 1);
    localparam int SLP_W = $clog2(MAX_SLIP + 1);
    localparam int LEN_W = $clog2(NTAPS + 1);
    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CHECK_M1  = CNT_W'(CHECK - 1);
    localparam logic [2:0]       CH_LAST   = 3'(NUM_CH - 1);
    localparam logic [4:0]       TAP_LAST  = 5'(NTAPS - 1);

    typedef enum logic [4:0] {
        IDLE, EN, EN_GAP, RST, RST_WAIT,
        SET_TAP, SET_GAP, LOAD, SETTLE_W, CHECK_W, NEXT_TAP,
        EVAL, SLIP, SLIP_WAIT,
        CENTER, CENTER_GAP, CENTER_LOAD, NEXT_CH, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         ch_q, ch_d;
    logic [4:0]         tap_q, tap_d;
    logic [SLP_W-1:0]   slips_q, slips_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               good_q, good_d;
    logic [4:0]         run_start_q, run_start_d;
    logic [4:0]         best_start_q, best_start_d;
    logic [4:0]         center_q, center_d;
    logic [LEN_W-1:0]   run_len_q, run_len_d;
    logic [LEN_W-1:0]   best_len_q, best_len_d;
    logic [NUM_CH-1:0]  fail_q, fail_d;
    logic               error_q, error_d;
    logic               clr_win;
    logic [LEN_W-1:0]   nlen;
    logic [4:0]         nstart;
    logic [31:0]        ch_mask;

    assign ch_mask   = 32'd1 << ch_q;
    assign busy_o    = (state_q != IDLE) && (state_q != DONE);
    assign done_o    = (state_q == DONE);
    assign error_o   = error_q;
    assign fail_ch_o = fail_q;

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            tap_q        <= '0;
            slips_q      <= '0;
            cnt_q        <= '0;
            good_q       <= 1'b0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            center_q     <= '0;
            fail_q       <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            tap_q        <= tap_d;
            slips_q      <= slips_d;
            cnt_q        <= cnt_d;
            good_q       <= good_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            center_q     <= center_d;
            fail_q       <= fail_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        tap_d        = tap_q;
        slips_d      = slips_q;
        cnt_d        = cnt_q;
        good_d       = good_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        center_d     = center_q;
        fail_d       = fail_q;
        error_d      = error_q;
        clr_win      = 1'b0;
        nlen         = '0;
        nstart       = run_start_q;
        bus_sel_o    = 1'b0;
        bus_wr_o     = 1'b0;
        bus_addr_o   = 4'h0;
        bus_dat_o    = 32'd0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    fail_d  = '0;
                    error_d = 1'b0;
                    state_d = EN;
                end
            end
            EN: begin
                bus_sel_o = 1'b1;
                bus_wr_o  = 1'b1;
                state_d   = EN_GAP;
            end
            EN_GAP: state_d = RST;
            RST: begin
                bus_sel_o = 1'b1;
                bus_wr_o  = 1'b1;
                bus_dat_o = 32'd2;
                cnt_d     = SETTLE_M1;
                state_d   = RST_WAIT;
            end
            RST_WAIT: begin
                if (cnt_q == '0) begin
                    ch_d    = '0;
                    slips_d = '0;
                    clr_win = 1'b1;
                    state_d = SET_TAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SET_TAP: begin
                bus_sel_o  = 1'b1;
                bus_wr_o   = 1'b1;
                bus_addr_o = 4'h2;
                bus_dat_o  = {21'd0, ch_q, 3'd0, tap_q};
                state_d    = SET_GAP;
            end
            SET_GAP: state_d = LOAD;
            LOAD: begin
                bus_sel_o  = 1'b1;
                bus_wr_o   = 1'b1;
                bus_addr_o = 4'h3;
                bus_dat_o  = ch_mask;
                cnt_d      = SETTLE_M1;
                state_d    = SETTLE_W;
            end
            SETTLE_W: begin
                if (cnt_q == '0) begin
                    cnt_d   = CHECK_M1;
                    good_d  = 1'b1;
                    state_d = CHECK_W;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CHECK_W: begin
                good_d = good_q & match_i[ch_q];
                if (cnt_q == '0) begin
                    state_d = NEXT_TAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            NEXT_TAP: begin
                // Strict '>' keeps the earliest of equally long windows.
                if (good_q) begin
                    nlen   = run_len_q + LEN_W'(1);
                    nstart = (run_len_q == '0) ? tap_q : run_start_q;
                end
                run_len_d   = nlen;
                run_start_d = nstart;
                if (nlen > best_len_q) begin
                    best_len_d   = nlen;
                    best_start_d = nstart;
                end
                if (tap_q != TAP_LAST) begin
                    tap_d   = tap_q + 1'b1;
                    state_d = SET_TAP;
                end else begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (best_len_q >= LEN_W'(MIN_WIN)) begin
                    center_d = best_start_q + 5'((best_len_q - LEN_W'(1)) >> 1);
                    state_d  = CENTER;
                end else if (slips_q < SLP_W'(MAX_SLIP)) begin
                    state_d = SLIP;
                end else begin
                    fail_d[ch_q] = 1'b1;
                    center_d     = '0;
                    state_d      = CENTER;
                end
            end
            SLIP: begin
                bus_sel_o  = 1'b1;
                bus_wr_o   = 1'b1;
                bus_addr_o = 4'h1;
                bus_dat_o  = ch_mask;
                slips_d    = slips_q + 1'b1;
                clr_win    = 1'b1;
                cnt_d      = SETTLE_M1;
                state_d    = SLIP_WAIT;
            end
            SLIP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = SET_TAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CENTER: begin
                bus_sel_o  = 1'b1;
                bus_wr_o   = 1'b1;
                bus_addr_o = 4'h2;
                bus_dat_o  = {21'd0, ch_q, 3'd0, center_q};
                state_d    = CENTER_GAP;
            end
            CENTER_GAP: state_d = CENTER_LOAD;
            CENTER_LOAD: begin
                bus_sel_o  = 1'b1;
                bus_wr_o   = 1'b1;
                bus_addr_o = 4'h3;
                bus_dat_o  = ch_mask;
                state_d    = NEXT_CH;
            end
            NEXT_CH: begin
                if (ch_q != CH_LAST) begin
                    ch_d    = ch_q + 1'b1;
                    slips_d = '0;
                    clr_win = 1'b1;
                    state_d = SET_TAP;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                error_d = |fail_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clr_win) begin
            tap_d        = '0;
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end
    end

endmodule

// File: tb/tb_ritc_align_sequencer.sv
// Self-checking bench: emulated datapath drives match_i from per-channel tap masks;
// expected bus traffic and results come from a window-search model of the rules.
module tb_ritc_align_sequencer;

    localparam int NUM_CH   = 6;
    localparam int NTAPS    = 32;
    localparam int SETTLE   = 4;
    localparam int CHECK    = 8;
    localparam int MIN_WIN  = 4;
    localparam int MAX_SLIP = 4;
    localparam int TAP_CYC  = 4 + SETTLE + CHECK;
    localparam int BUDGET   = NUM_CH * (MAX_SLIP + 1) * NTAPS * TAP_CYC + 400;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NUM_CH-1:0] match_v = '0;
    logic              busy_o, done_o, error_o;
    logic [NUM_CH-1:0] fail_ch_o;
    logic              bus_sel_o, bus_wr_o;
    logic [3:0]        bus_addr_o;
    logic [31:0]       bus_dat_o;

    ritc_align_sequencer #(
        .NUM_CH(NUM_CH), .NTAPS(NTAPS), .SETTLE(SETTLE), .CHECK(CHECK),
        .MIN_WIN(MIN_WIN), .MAX_SLIP(MAX_SLIP)
    ) dut (
        .user_clk_i   (clk),
        .user_rst_n_i (rst_n),
        .start_i      (start),
        .match_i      (match_v),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .fail_ch_o    (fail_ch_o),
        .bus_sel_o    (bus_sel_o),
        .bus_wr_o     (bus_wr_o),
        .bus_addr_o   (bus_addr_o),
        .bus_dat_o    (bus_dat_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    int errs = 0;
    int checks = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];
    logic [NUM_CH-1:0] exp_fail;
    logic [31:0] good_m  [NUM_CH][MAX_SLIP+1];
    logic [31:0] flaky_m [NUM_CH][MAX_SLIP+1];

    int slip_lvl [NUM_CH];
    int cur_tap  [NUM_CH];
    int since_ld [NUM_CH];
    int glitch_at[NUM_CH];
    int pend_ch = 0, pend_tap = 0;
    int cyc = 0, done_cnt = 0;
    int last_tap_cyc = -1, last_ch = 0, last_tap = 0;
    bit prev_wr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Emulated datapath plus bus monitor.
    always @(negedge clk) begin
        int lvl;
        cyc++;
        for (int c = 0; c < NUM_CH; c++) since_ld[c]++;
        if (!rst_n) begin
            prev_wr      = 1'b0;
            last_tap_cyc = -1;
        end else begin
            chk("sel_eq_wr", 32'(bus_sel_o), 32'(bus_wr_o));
            if (done_o) begin
                done_cnt++;
                chk("busy_low_at_done", 32'(busy_o), 32'd0);
            end
            if (bus_sel_o && bus_wr_o) begin
                chk("one_cycle_strobe", 32'(prev_wr), 32'd0);
                obs_q.push_back('{bus_addr_o, bus_dat_o});
                case (bus_addr_o)
                    4'h0: if (bus_dat_o[1]) for (int c = 0; c < NUM_CH; c++) slip_lvl[c] = 0;
                    4'h1: for (int c = 0; c < NUM_CH; c++) if (bus_dat_o[c]) slip_lvl[c]++;
                    4'h2: begin
                        if (last_tap_cyc >= 0 && int'(bus_dat_o[10:8]) == last_ch &&
                            int'(bus_dat_o[4:0]) == last_tap + 1)
                            chk("tap_period", 32'(cyc - last_tap_cyc), 32'(TAP_CYC));
                        pend_ch      = int'(bus_dat_o[10:8]);
                        pend_tap     = int'(bus_dat_o[4:0]);
                        last_tap_cyc = cyc;
                        last_ch      = pend_ch;
                        last_tap     = pend_tap;
                    end
                    4'h3: for (int c = 0; c < NUM_CH; c++) begin
                        if (bus_dat_o[c]) begin
                            if (c == pend_ch) cur_tap[c] = pend_tap;
                            since_ld[c]  = 0;
                            glitch_at[c] = int'($urandom_range(SETTLE + CHECK - 1, SETTLE + 2));
                        end
                    end
                    default: ;
                endcase
            end
            prev_wr = bus_sel_o && bus_wr_o;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            lvl = (slip_lvl[c] > MAX_SLIP) ? MAX_SLIP : slip_lvl[c];
            if (good_m[c][lvl][cur_tap[c]])       match_v[c] = 1'b1;
            else if (flaky_m[c][lvl][cur_tap[c]]) match_v[c] = (since_ld[c] != glitch_at[c]);
            else                                  match_v[c] = 1'b0;
        end
    end

    // Widest fully-set window, earliest start among equals.
    function automatic void best_window(input logic [31:0] m, output int bs, output int bl);
        bit all;
        bs = 0;
        bl = 0;
        for (int len = NTAPS; len >= 1 && bl == 0; len--) begin
            for (int st = 0; st + len <= NTAPS && bl == 0; st++) begin
                all = 1'b1;
                for (int k = st; k < st + len; k++) if (!m[k]) all = 1'b0;
                if (all) begin
                    bs = st;
                    bl = len;
                end
            end
        end
    endfunction

    function automatic logic [31:0] tap_word(input int c, input int t);
        return 32'((c << 8) | t);
    endfunction

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    task automatic build_expected();
        int bs, bl, used, ctr;
        bit found;
        exp_q.delete();
        exp_fail = '0;
        exp_q.push_back('{4'h0, 32'h0});
        exp_q.push_back('{4'h0, 32'h2});
        for (int c = 0; c < NUM_CH; c++) begin
            found = 1'b0;
            used  = MAX_SLIP;
            ctr   = 0;
            for (int s = 0; s <= MAX_SLIP; s++) begin
                if (!found) begin
                    best_window(good_m[c][s], bs, bl);
                    if (bl >= MIN_WIN) begin
                        found = 1'b1;
                        used  = s;
                        ctr   = bs + (bl - 1) / 2;
                    end
                end
            end
            if (!found) exp_fail[c] = 1'b1;
            for (int s = 0; s <= used; s++) begin
                for (int t = 0; t < NTAPS; t++) begin
                    exp_q.push_back('{4'h2, tap_word(c, t)});
                    exp_q.push_back('{4'h3, 32'd1 << c});
                end
                if (s < used) exp_q.push_back('{4'h1, 32'd1 << c});
            end
            exp_q.push_back('{4'h2, tap_word(c, ctr)});
            exp_q.push_back('{4'h3, 32'd1 << c});
        end
    endtask

    task automatic set_all_ones();
        for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s <= MAX_SLIP; s++) begin
                good_m[c][s]  = 32'hFFFF_FFFF;
                flaky_m[c][s] = 32'h0;
            end
    endtask

    task automatic gen_random();
        logic [31:0] m;
        int nw, st, ln;
        for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s <= MAX_SLIP; s++) begin
                m  = '0;
                nw = int'($urandom_range(3, 0));
                for (int k = 0; k < nw; k++) begin
                    st = int'($urandom_range(31, 0));
                    ln = int'($urandom_range(10, 1));
                    for (int t = st; t < st + ln && t < NTAPS; t++) m[t] = 1'b1;
                end
                if ($urandom_range(3, 0) == 0) m[$urandom_range(31, 0)] = 1'b1;
                good_m[c][s]  = m;
                flaky_m[c][s] = $urandom & ~m;
            end
    endtask

    function automatic logic [31:0] last_center(input int c);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        foreach (obs_q[i]) if (obs_q[i].a == 4'h2 && obs_q[i].d[10:8] == 3'(c)) r = obs_q[i].d;
        return r;
    endfunction

    function automatic int count_wr(input logic [3:0] a, input logic [31:0] d);
        int n;
        n = 0;
        foreach (obs_q[i]) if (obs_q[i].a == a && obs_q[i].d == d) n++;
        return n;
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_seq(input string tag, input bit poke_busy);
        bit seen;
        int n;
        obs_q.delete();
        done_cnt = 0;
        build_expected();
        pulse_start();
        chk({tag, "_busy_after_start"}, 32'(busy_o), 32'd1);
        chk({tag, "_fail_cleared"}, 32'(fail_ch_o), 32'd0);
        chk({tag, "_error_cleared"}, 32'(error_o), 32'd0);
        if (poke_busy) begin
            repeat (100) @(negedge clk);
            pulse_start();
        end
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_error"}, 32'(error_o), 32'(|exp_fail));
        chk({tag, "_fail_mask"}, 32'(fail_ch_o), 32'(exp_fail));
        chk({tag, "_busy_idle"}, 32'(busy_o), 32'd0);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_write_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_wr%0d", tag, i), {28'd0, obs_q[i].a} ^ obs_q[i].d ^ 32'(i),
                {28'd0, exp_q[i].a} ^ exp_q[i].d ^ 32'(i));
            if (obs_q[i] !== exp_q[i]) break;
        end
        if (poke_busy) begin
            n = obs_q.size();
            repeat (60) @(negedge clk);
            chk({tag, "_no_restart_busy"}, 32'(busy_o), 32'd0);
            chk({tag, "_no_restart_writes"}, 32'(obs_q.size()), 32'(n));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_error"}, 32'(error_o), 32'd0);
        chk({tag, "_fail"}, 32'(fail_ch_o), 32'd0);
        chk({tag, "_sel"}, 32'(bus_sel_o), 32'd0);
        chk({tag, "_wr"}, 32'(bus_wr_o), 32'd0);
        chk({tag, "_addr"}, 32'(bus_addr_o), 32'd0);
        chk({tag, "_dat"}, bus_dat_o, 32'd0);
    endtask

    initial begin
        bit seen;
        int n;
        for (int c = 0; c < NUM_CH; c++) begin
            slip_lvl[c]  = 0;
            cur_tap[c]   = 0;
            since_ld[c]  = 0;
            glitch_at[c] = -1;
        end
        set_all_ones();
        @(negedge clk);
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        set_all_ones();
        run_seq("A", 1'b1);
        chk("A_no_slips", 32'(count_wr(4'h1, 32'h01) + count_wr(4'h1, 32'h02)), 32'd0);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("A_center_ch%0d", c), last_center(c), tap_word(c, 15));

        set_all_ones();
        good_m[0][0] = win(5, 7);
        for (int s = 1; s <= MAX_SLIP; s++) good_m[0][s] = win(8, 15);
        for (int s = 0; s <= MAX_SLIP; s++) begin
            good_m[1][s] = win(3, 6) | win(20, 27);
            good_m[2][s] = win(10, 20);
        end
        run_seq("B", 1'b0);
        chk("B_ch0_slip_once", 32'(count_wr(4'h1, 32'h01)), 32'd1);
        chk("B_ch0_center", last_center(0), 32'h00B);
        chk("B_ch1_center", last_center(1), 32'h117);
        chk("B_ch2_center", last_center(2), 32'h20F);

        set_all_ones();
        for (int s = 0; s <= MAX_SLIP; s++) begin
            good_m[1][s] = win(2, 5) | win(9, 12);
            good_m[4][s] = 32'h0;
        end
        run_seq("C", 1'b0);
        chk("C_ch1_tie_center", last_center(1), 32'h103);
        chk("C_ch4_slips", 32'(count_wr(4'h1, 32'h10)), 32'd4);
        chk("C_ch4_center", last_center(4), 32'h400);
        chk("C_fail_mask", 32'(fail_ch_o), 32'h10);
        chk("C_error", 32'(error_o), 32'd1);
        chk("C_ch5_center", last_center(5), 32'h50F);

        gen_random();
        run_seq("D", 1'b0);
        gen_random();
        run_seq("E", 1'b0);

        set_all_ones();
        obs_q.delete();
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (bus_wr_o && bus_addr_o == 4'h3 && bus_dat_o == 32'h8) seen = 1'b1;
        end
        chk("R_reach_ch3", 32'(seen), 32'd1);
        repeat (SETTLE + 4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("R_async");
        n = obs_q.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("R_bus_idle", 32'(bus_sel_o | bus_wr_o), 32'd0);
        end
        chk("R_no_writes", 32'(obs_q.size()), 32'(n));
        rst_n = 1'b1;
        gen_random();
        run_seq("R2", 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
